// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the RISC-V core and its boot-time loader.
package riscv_pkg;
    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam int IMEM_DEPTH_DEFAULT = 256;
    typedef enum logic [1:0] {LOAD, PAD, HOLD, RUN} loader_state_e;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction ROM, pads with NOP, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to expose a running sum of accepted words on checksum.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = NOP_INSN,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err_overflow,
    output logic [31:0]       checksum
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    loader_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic [3:0] hold_q, hold_d;
    logic imem_we_q, imem_we_d, core_rst_q, core_rst_d, done_q, done_d, err_overflow_q, err_overflow_d;
    logic beat, at_end;
    assign s_ready = state_q == LOAD;
    assign beat = s_valid && s_ready;
    assign at_end = addr_q == LAST_ADDR;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        imem_we_d = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        hold_d = hold_q;
        core_rst_d = core_rst_q;
        done_d = done_q;
        err_overflow_d = err_overflow_q;
        case (state_q)
            LOAD: if (beat) begin
                imem_we_d = 1'b1;
                imem_addr_d = addr_q;
                imem_wdata_d = s_data;
                addr_d = at_end ? addr_q : addr_q + 1'b1;
                state_d = at_end ? HOLD : (s_last ? PAD : LOAD);
                err_overflow_d = err_overflow_q | (at_end & ~s_last);
            end
            PAD: begin
                imem_we_d = 1'b1;
                imem_addr_d = addr_q;
                imem_wdata_d = NOP_WORD;
                addr_d = at_end ? addr_q : addr_q + 1'b1;
                state_d = at_end ? HOLD : PAD;
            end
            HOLD: begin
                hold_d = hold_q + 4'd1;
                if (hold_q == 4'(HOLD_CYCLES)) begin
                    state_d = RUN;
                    core_rst_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            RUN: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            addr_q <= '0;
            imem_we_q <= 1'b0;
            imem_addr_q <= '0;
            imem_wdata_q <= '0;
            hold_q <= '0;
            core_rst_q <= 1'b1;
            done_q <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            imem_we_q <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            hold_q <= hold_d;
            core_rst_q <= core_rst_d;
            done_q <= done_d;
            err_overflow_q <= err_overflow_d;
        end
    end
    assign imem_we = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst = core_rst_q;
    assign done = done_q;
    assign err_overflow = err_overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    // Beats only occur in LOAD, so the sum freezes once the stream ends.
    logic [31:0] checksum_q, checksum_d;
    always_comb checksum_d = beat ? checksum_q + s_data : checksum_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) checksum_q <= '0;
        else checksum_q <= checksum_d;
    end
    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams checked cycle-by-cycle against an image/timing model of the loader.
module tb_imem_loader;
    import riscv_pkg::*;
    localparam int DEPTH = 256;
    localparam int HOLD = 2;
    logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0;
    logic [31:0] s_data = '0;
    logic s_ready, imem_we, core_rst, done, err_overflow;
    logic [7:0] imem_addr;
    logic [31:0] imem_wdata, checksum;
    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .done(done), .err_overflow(err_overflow), .checksum(checksum)
    );

    int total = 0, bad = 0;
    logic [31:0] words [0:256];
    logic [31:0] rom [0:255];
    logic [31:0] exp_img [0:255];
    logic [31:0] prog [0:7] = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302423,
                                32'h00A02203, 32'h0031A463, 32'h06300293, 32'h03700293};
    int nwr, nbeat, nacc, cyc, c0, fall;
    bit beat_prev, chk_en = 1'b0;
    logic [31:0] msum;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expected ROM image: program words from address 0, NOP everywhere after.
    task automatic model_start(input int n);
        nacc = n > DEPTH ? DEPTH : n;
        nwr = 0; nbeat = 0; beat_prev = 1'b0; cyc = 0; c0 = -1; fall = -1; msum = '0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_img[a] = a < n ? words[a] : NOP_INSN;
            rom[a] = 32'hDEADBEEF;
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        cyc++;
        if (nwr < nacc) check("we_follows_beat", 32'(imem_we), 32'(beat_prev));
        else if (nwr < DEPTH) check("pad_we", 32'(imem_we), 32'd1);
        else check("idle_we", 32'(imem_we), 32'd0);
        if (imem_we) begin
            if (nwr < DEPTH) begin
                check("waddr", 32'(imem_addr), 32'(nwr));
                check("wdata", imem_wdata, exp_img[nwr]);
                if (nwr < nacc) msum += exp_img[nwr];
            end
            rom[imem_addr] = imem_wdata;
            nwr++;
        end
        check("s_ready", 32'(s_ready), 32'(nbeat < nacc));
        check("done_vs_core_rst", 32'(done), 32'(!core_rst));
        if (nwr < DEPTH) check("early_release", 32'(core_rst), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("checksum", checksum, msum);
`else
        check("checksum", checksum, 32'h0);
`endif
        if (!core_rst && fall < 0) fall = cyc;
        beat_prev = s_valid && s_ready;
        if (beat_prev) begin
            if (c0 < 0) c0 = cyc;
            nbeat++;
        end
    end

    task automatic reset_values(input string tag);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err_overflow), 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic do_reset(input int n);
        chk_en = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; rst = 1'b1;
        @(negedge clk); #1;
        reset_values("rst");
        @(negedge clk);
        rst = 1'b0;
        model_start(n);
        @(posedge clk); #1;
        chk_en = 1'b1;
    endtask

    task automatic drive(input int n, input int last_at, input bit toggle);
        int i = 0;
        bit acc;
        for (int g = 0; g < 2 * n + 20 && i < n; g++) begin
            @(posedge clk); #1;
            s_valid = !toggle || (g % 2 == 0);
            s_data = words[i];
            s_last = (i == last_at);
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) i++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic finish_test(input string tag, input bit exp_err, input bit chk_lat);
        int mism = 0;
        for (int k = 0; k < 600 && !done; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err_overflow), 32'(exp_err));
        check({tag, "_writes"}, 32'(nwr), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) if (rom[a] !== exp_img[a]) mism++;
        check({tag, "_image_mismatches"}, 32'(mism), 32'd0);
        if (chk_lat) check({tag, "_release_latency"}, 32'(fall - c0), 32'(DEPTH + HOLD + 1));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 8; i++) words[i] = prog[i];
        do_reset(8);
        drive(8, 7, 1'b0);
        finish_test("b2b", 1'b0, 1'b1);
        check("b2b_rom2_literal", rom[2], 32'h002081B3);
        check("b2b_rom200_literal", rom[200], 32'h00000013);
        check("b2b_latency_literal", 32'(fall - c0), 32'd259);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("b2b_checksum_literal", checksum, 32'h0B827308);
`else
        check("b2b_checksum_off", checksum, 32'h0);
`endif

        do_reset(8);
        drive(8, 7, 1'b1);
        finish_test("toggle", 1'b0, 1'b0);

        for (int i = 0; i < 257; i++) words[i] = 32'hC0DE0000 | 32'(i);
        do_reset(256);
        drive(256, 255, 1'b0);
        finish_test("full", 1'b0, 1'b1);

        do_reset(257);
        drive(257, -1, 1'b0);
        finish_test("overflow", 1'b1, 1'b1);
        check("overflow_s_ready", 32'(s_ready), 32'd0);
        check("overflow_rom255", rom[255], 32'hC0DE00FF);

        for (int i = 0; i < 8; i++) words[i] = prog[i];
        do_reset(8);
        drive(8, 7, 1'b0);
        k = 0;
        while (k < 400 && !(imem_we && imem_addr == 8'd100)) begin
            @(negedge clk);
            k++;
        end
        check("midpad_reached", 32'(imem_we && imem_addr == 8'd100), 32'd1);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midpad_core_rst", 32'(core_rst), 32'd1);
        check("midpad_we", 32'(imem_we), 32'd0);
        check("midpad_addr", 32'(imem_addr), 32'd0);
        words[0] = 32'h00100093; words[1] = 32'h00200113; words[2] = 32'h002081B3;
        do_reset(3);
        drive(3, 2, 1'b0);
        finish_test("reload", 1'b0, 1'b1);
        check("reload_rom3_nop", rom[3], 32'h00000013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of riscv_pipeline.
- Accepts a valid/ready stream of 32-bit instruction words and writes them into the core's instruction ROM from address 0.
- Pads every remaining ROM location with NOP (ADDI x0,x0,0 = 32'h00000013).
- Holds the core in reset until the ROM image is complete, then releases it, so no hierarchical ROM preloading is needed.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in ROM
- ADDR_W, 8, word-address width; must equal clog2(DEPTH)
- NOP_WORD, 32'h00000013, fill value written to unloaded locations
- HOLD_CYCLES, 2, cycles core_rst stays high after the last ROM write (range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  upstream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  32  instruction word
- s_last  in  1  marks the final program word; sampled with the s_valid&&s_ready beat
- imem_we  out  1  ROM write strobe
- imem_addr  out  ADDR_W  ROM word address
- imem_wdata  out  32  ROM write data
- core_rst  out  1  active-high reset to riscv_pipeline
- done  out  1  image loaded and core released
- err_overflow  out  1  sticky; stream reached DEPTH words without s_last
- checksum  out  32  see Optional Feature

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=LOAD, addr=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err_overflow=0, checksum=0.
  - Asserting rst at any point, including mid-LOAD or mid-PAD, returns to these values immediately.
  - The partially written ROM is not cleared.
- All outputs are registered except s_ready, which is combinational from state: 1 only in LOAD.
- States:
  - LOAD: on each s_valid&&s_ready beat, the next cycle drives imem_we=1, imem_addr=addr, imem_wdata=s_data (1-cycle write latency), then addr++. Exit conditions on the accepted beat:
    - s_last=1 and addr<DEPTH-1 -> PAD, starting at addr+1.
    - s_last=1 and addr==DEPTH-1 -> HOLD (ROM full, no padding).
    - s_last=0 and addr==DEPTH-1 -> HOLD with err_overflow set to 1 (sticky until rst); the extra words are never accepted because s_ready=0.
    - No beat in a cycle -> imem_we=0 that cycle.
  - PAD: writes NOP_WORD one location per cycle (imem_we=1 continuously) from the current addr through DEPTH-1, then goes to HOLD. s_valid is ignored.
  - HOLD: imem_we=0. An internal counter runs HOLD_CYCLES cycles; on expiry -> RUN.
  - RUN: core_rst=0 and done=1 on the same edge. Terminal until rst; s_ready=0 and imem_we=0 permanently.
- addr never wraps. Writes beyond DEPTH-1 are impossible by construction.
- Zero-length program: not supported. The first beat is always program word 0.
- Throughput: 1 word/cycle when s_valid is held high. The cycle count from the first beat to core_rst falling is N + (DEPTH-N) + HOLD_CYCLES + 1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: checksum holds the 32-bit modulo-2^32 sum of all accepted s_data words; padding words are excluded.
  - It updates on the same edge as the corresponding imem_we.
  - It is frozen from HOLD onward.
- Undefined: checksum is tied to 32'h0 and no adder is synthesized.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSN = 32'h00000013
  - the loader state enum (LOAD, PAD, HOLD, RUN)
  - IMEM_DEPTH_DEFAULT = 256
- No sub-module. The write-address counter and hold counter are simple enough to stay inline.

Test Plan:
- Stream 8 words back-to-back (00500093, 00700113, 002081B3, 00302423, 00A02203, 0031A463, 06300293, 03700293), s_last on the 8th.
  - Required: ROM[0..7] match the stream and ROM[8..255] = 00000013.
  - Required: core_rst falls exactly 8+248+2+1 cycles after the first beat.
  - Required: done=1, err_overflow=0.
  - Then run riscv_pipeline 60 cycles and require x1=5, x2=7, x3=12, x4=12, x5=55, mem word 2 = 12.
- Same 8 words with s_valid toggling 1/0 each cycle -> identical ROM image; no write occurs in cycles without a beat.
- 256 words, s_last on word 255 -> no PAD writes, err_overflow=0, done rises after HOLD.
- 257 words with no s_last -> 256 writes, err_overflow=1, s_ready=0 after the 256th beat, and the 257th word is never written.
- Assert rst mid-PAD at addr=100 -> core_rst=1, imem_we=0, addr=0 immediately; a subsequent 3-word reload pads locations 3..255.
- With IMEM_LOADER_CHECKSUM_EN defined, the 8-word stream -> checksum = modulo-2^32 sum of the 8 words, held stable after HOLD. Without the macro, checksum = 0.
